// File: rtl/addsub_sequencer.sv
// addsub_sequencer: W-bit add/subtract built from one shared 4-bit adder,
// one nibble per cycle, LSB nibble first, with a start/busy/done handshake.
module addsub_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 ovf,
    output logic [3:0]           alu_x,
    output logic [3:0]           alu_y,
    output logic                 alu_ci,
    input  logic [3:0]           alu_s,
    input  logic                 alu_c3,
    input  logic                 alu_c4
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;          // already inverted for subtract
    logic             r_carry;      // carry chained between nibbles
    logic [IDX_W-1:0] r_idx;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0]       w_a_nib   [NIBBLES];
    logic [3:0]       w_b_nib   [NIBBLES];
    logic [3:0]       r_res_nib [NIBBLES];

    logic             w_accept;
    logic             w_run;
    logic             w_last;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = (r_idx == LAST_IDX);

    assign cout = r_cout;
    assign ovf  = r_ovf;

    // Split the latched operands into nibbles and hold one result register per nibble.
    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
            assign w_a_nib[gi]         = r_a[4*gi +: 4];
            assign w_b_nib[gi]         = r_b[4*gi +: 4];
            assign result[4*gi +: 4]   = r_res_nib[gi];

            // Capture this nibble's sum when the sequencer reaches it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_res_nib[gi] <= 4'd0;
                end else if (w_run && (r_idx == IDX_W'(gi))) begin
                    r_res_nib[gi] <= alu_s;
                end
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and handshake/adder-steering outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        alu_x        = 4'd0;
        alu_y        = 4'd0;
        alu_ci       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy   = 1'b1;
                alu_x  = w_a_nib[r_idx];
                alu_y  = w_b_nib[r_idx];
                alu_ci = r_carry;
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Operand latch, nibble index, carry chain and final flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtract becomes a + ~b + 1: invert b now, inject the +1 as first carry.
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
        end else if (w_run) begin
            r_carry <= alu_c4;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) begin
                // Signed overflow: carry into MSB differs from carry out of MSB.
                r_cout <= alu_c4;
                r_ovf  <= alu_c4 ^ alu_c3;
            end
        end
    end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Testbench for addsub_sequencer: behavioural 4-bit adder on the alu_* side,
// vector table, handshake corner cases and randomized word-level model checks.
module tb_addsub_sequencer;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic [3:0]   alu_x;
    logic [3:0]   alu_y;
    logic         alu_ci;
    logic [3:0]   alu_s;
    logic         alu_c3;
    logic         alu_c4;

    int tests;
    int fails;

    addsub_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf),
        .alu_x  (alu_x),
        .alu_y  (alu_y),
        .alu_ci (alu_ci),
        .alu_s  (alu_s),
        .alu_c3 (alu_c3),
        .alu_c4 (alu_c4)
    );

    // Behavioural 4-bit adder in plain add mode.
    logic [4:0] sum5;
    logic [3:0] low4;
    assign sum5   = {1'b0, alu_x} + {1'b0, alu_y} + {4'd0, alu_ci};
    assign low4   = {1'b0, alu_x[2:0]} + {1'b0, alu_y[2:0]} + {3'd0, alu_ci};
    assign alu_s  = sum5[3:0];
    assign alu_c4 = sum5[4];
    assign alu_c3 = low4[3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_res;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Word-level model from the arithmetic definition (unsigned carry, signed range).
    function automatic void ref_model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                      input logic sv, output logic [W-1:0] r,
                                      output logic c, output logic o);
        int ua, ub, sa, sb, ures, sres;
        ua = int'(av);
        ub = int'(bv);
        sa = int'($signed(av));
        sb = int'($signed(bv));
        if (sv) begin
            ures = ua - ub;
            sres = sa - sb;
            c    = (ua >= ub);
        end else begin
            ures = ua + ub;
            sres = sa + sb;
            c    = (ures > 65535);
        end
        r = ures[W-1:0];
        o = (sres > 32767) || (sres < -32768);
    endfunction

    // Called #1 after the start edge; scrambles a/b/sub every cycle while waiting.
    task automatic wait_done(output int edges, output int bcnt);
        edges = 0;
        bcnt  = 0;
        while (!done && edges < 20) begin
            if (busy) bcnt++;
            a   = W'($urandom);
            b   = W'($urandom);
            sub = 1'($urandom);
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                         output logic [W-1:0] r, output logic c, output logic o);
        int edges, bcnt;
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(edges, bcnt);
        check("latency", edges, NIBBLES);
        check("busy_cycles", bcnt, NIBBLES);
        r = result; c = cout; o = ovf;
        @(posedge clk); #1;
        check("done_width", {31'd0, done}, 0);
    endtask

    initial begin
        logic [W-1:0] r, er;
        logic         c, o, ec, eo;
        int           edges, bcnt, done_seen;

        tests = 0;
        fails = 0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;

        vecs[0] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0001, 16'h0002, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_result", {16'd0, result}, 0);
        check("rst_cout", {31'd0, cout}, 0);
        check("rst_ovf", {31'd0, ovf}, 0);
        check("rst_alu", {23'd0, alu_x, alu_y, alu_ci}, 0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, c, o);
            $display("[TB] vec %0d: %h %s %h -> %h c=%0b v=%0b", i, vecs[i].a,
                     vecs[i].sub ? "-" : "+", vecs[i].b, r, c, o);
            check("vec_result", {16'd0, r}, {16'd0, vecs[i].exp_res});
            check("vec_cout", {31'd0, c}, {31'd0, vecs[i].exp_cout});
            check("vec_ovf", {31'd0, o}, {31'd0, vecs[i].exp_ovf});
        end

        // Busy protection: start held high, operands scrambled during RUN/DONE
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        wait_done(edges, bcnt);
        check("bp_latency", edges, NIBBLES);
        check("bp_result", {16'd0, result}, 32'h3333);
        a = 16'h0005; b = 16'h0003; sub = 1'b1;
        @(posedge clk); #1;
        check("bp_idle_busy", {31'd0, busy}, 0);
        check("bp_idle_done", {31'd0, done}, 0);
        @(posedge clk); #1;
        check("bp_accept", {31'd0, busy}, 1);
        start = 1'b0;
        wait_done(edges, bcnt);
        check("bp2_latency", edges, NIBBLES);
        check("bp2_result", {16'd0, result}, 32'h0002);
        check("bp2_cout", {31'd0, cout}, 1);
        check("bp2_ovf", {31'd0, ovf}, 0);
        $display("[TB] busy-protect: second op -> %h", result);
        @(posedge clk); #1;

        // Reset mid-operation
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mr_busy", {31'd0, busy}, 0);
        check("mr_done", {31'd0, done}, 0);
        check("mr_result", {16'd0, result}, 0);
        check("mr_cout", {31'd0, cout}, 0);
        check("mr_ovf", {31'd0, ovf}, 0);
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("mr_no_done", done_seen, 0);
        do_op(16'h1234, 16'h4321, 1'b0, r, c, o);
        check("mr_after", {16'd0, r}, 32'h5555);
        $display("[TB] reset mid-op, then 1234+4321 -> %h", r);

        // Reset and start on the same edge: start is dropped
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 16'h0F0F; b = 16'h0101;
        @(posedge clk); #1;
        check("rs_busy0", {31'd0, busy}, 0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rs_busy1", {31'd0, busy}, 0);
        $display("[TB] rst+start same edge: busy=%0b", busy);

        // Random operations against the word-level model
        for (int i = 0; i < 200; i++) begin
            logic [W-1:0] ra, rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            ref_model(ra, rb, rs, er, ec, eo);
            do_op(ra, rb, rs, r, c, o);
            $display("[TB] rnd %0d: %h %s %h -> %h c=%0b v=%0b", i, ra, rs ? "-" : "+",
                     rb, r, c, o);
            check("rnd_result", {16'd0, r}, {16'd0, er});
            check("rnd_cout", {31'd0, c}, {31'd0, ec});
            check("rnd_ovf", {31'd0, o}, {31'd0, eo});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
